// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg
// Shared definitions for the 7-segment scan reader:
//   - the ten active-low digit patterns (bit7=dp .. bit0=a) and the blank pattern
//   - the special codes reported for blank and undecodable patterns
//   - the per-dwell capture FSM state type
package seg_scan_decoder_pkg;

  localparam logic [7:0] PAT_0 = 8'hC0;
  localparam logic [7:0] PAT_1 = 8'hF9;
  localparam logic [7:0] PAT_2 = 8'hA4;
  localparam logic [7:0] PAT_3 = 8'hB0;
  localparam logic [7:0] PAT_4 = 8'h99;
  localparam logic [7:0] PAT_5 = 8'h92;
  localparam logic [7:0] PAT_6 = 8'h82;
  localparam logic [7:0] PAT_7 = 8'hF8;
  localparam logic [7:0] PAT_8 = 8'h80;
  localparam logic [7:0] PAT_9 = 8'h98;
  localparam logic [7:0] BLANK = 8'hFF;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;

  // IDLE: no single anode selected; SETTLE: counting identical samples;
  // HELD: the current dwell has already been captured.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
// Frame hand-off bus between the scan reader and its consumer.
//   frame_digits : 4*DIGITS decoded codes, digit i at [4i+3:4i]
//   frame_blank  : per-digit "pattern was blank"
//   frame_bad    : per-digit "pattern was not decodable"
//   frame_valid  : frame available (held until accepted)
//   frame_ready  : consumer accepts the frame
//   overrun      : sticky, a completed frame was dropped
// master = frame producer (the reader), slave = frame consumer.
interface seg_scan_decoder_if #(
  parameter int DIGITS = 8
);

  logic [4*DIGITS-1:0] frame_digits;
  logic [DIGITS-1:0]   frame_blank;
  logic [DIGITS-1:0]   frame_bad;
  logic                frame_valid;
  logic                frame_ready;
  logic                overrun;

  modport master (
    output frame_digits, frame_blank, frame_bad, frame_valid, overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_digits, frame_blank, frame_bad, frame_valid, overrun,
    output frame_ready
  );

endinterface

// File: rtl/seg_scan_decoder_pattern.sv
// seg_pattern_decode
// Combinational inverse of the digit-to-pattern encoder table.
//   pattern : active-low segment pattern (bit7=dp .. bit0=a)
//   code    : digit 0..9, CODE_BLANK for blank, CODE_BAD otherwise
//   blank   : pattern was all segments off
//   bad     : pattern is neither a digit nor blank
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] code,
  output logic       blank,
  output logic       bad
);

  // Exact 8-bit match; anything outside the table is flagged bad.
  always_comb begin
    code  = CODE_BAD;
    blank = 1'b0;
    bad   = 1'b0;
    case (pattern)
      PAT_0:   code = 4'd0;
      PAT_1:   code = 4'd1;
      PAT_2:   code = 4'd2;
      PAT_3:   code = 4'd3;
      PAT_4:   code = 4'd4;
      PAT_5:   code = 4'd5;
      PAT_6:   code = 4'd6;
      PAT_7:   code = 4'd7;
      PAT_8:   code = 4'd8;
      PAT_9:   code = 4'd9;
      BLANK: begin
        code  = CODE_BLANK;
        blank = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Reads a multiplexed 7-segment display bus, waits for each digit's pattern
// to be stable for STABLE_CYCLES samples, decodes it and assembles a frame of
// DIGITS codes which is handed out over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   an         : active-low anode selects, expected one-hot-low
//   seg        : active-low segment pattern (bit7=dp .. bit0=a)
//   frame      : frame hand-off bus (master side)
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CW            = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGITS-1:0]         an,
  input  logic [7:0]                seg,
  seg_scan_decoder_if.master        frame
);

  localparam int IW = $clog2(DIGITS);

  logic [DIGITS-1:0]   an_q, an_p;
  logic [7:0]          seg_q, seg_p;
  scan_state_t         state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx;
  logic [4:0]          zeros;
  logic                valid_sel;
  logic                changed;
  logic                capture;
  logic [3:0]          dec_code;
  logic                dec_blank, dec_bad;
  logic [DIGITS-1:0]   seen, seen_n;
  logic [4*DIGITS-1:0] slot_digits;
  logic [DIGITS-1:0]   slot_blank, slot_bad;
  logic                complete;
  logic                accept;

  // Input register plus a second copy so every decision compares the current
  // registered sample against the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= 8'hFF;
      an_p  <= '1;
      seg_p <= 8'hFF;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  // Locate the single low anode; more or fewer than one low means no digit.
  always_comb begin
    zeros = '0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        zeros = zeros + 5'd1;
        idx   = i[IW-1:0];
      end
    end
    valid_sel = (zeros == 5'd1);
    changed   = (an_q != an_p) || (seg_q != seg_p);
  end

  seg_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (dec_code),
    .blank   (dec_blank),
    .bad     (dec_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Dwell tracking. A fresh dwell (or leaving IDLE) counts as the first
  // sample; the capture fires on the cycle the count reaches STABLE_CYCLES,
  // after which HELD suppresses re-capture until the sample changes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!valid_sel) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (changed || state == ST_IDLE) begin
      state_n = ST_SETTLE;
      cnt_n   = CW'(1);
    end else if (state == ST_SETTLE) begin
      cnt_n = cnt + CW'(1);
    end
    if (state_n == ST_SETTLE && cnt_n == CW'(STABLE_CYCLES)) begin
      capture = 1'b1;
      state_n = ST_HELD;
    end
  end

  // A frame is complete once every position has been seen; seen is cleared
  // at completion, so this is only true on the cycle after the last capture.
  always_comb begin
    complete = &seen;
    accept   = frame.frame_valid && frame.frame_ready;
    seen_n   = complete ? '0 : seen;
    if (capture) begin
      seen_n[idx] = 1'b1;
    end
  end

  // Slot storage; a later dwell on the same position overwrites its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      slot_digits <= '0;
      slot_blank  <= '0;
      slot_bad    <= '0;
    end else begin
      seen <= seen_n;
      if (capture) begin
        slot_digits[{idx, 2'b00} +: 4] <= dec_code;
        slot_blank[idx]                <= dec_blank;
        slot_bad[idx]                  <= dec_bad;
      end
    end
  end

  // Output frame and handshake. A completion that coincides with the accept
  // loads straight away; otherwise a completion while a frame is still
  // pending is dropped and flagged as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.frame_digits <= '0;
      frame.frame_blank  <= '0;
      frame.frame_bad    <= '0;
      frame.frame_valid  <= 1'b0;
      frame.overrun      <= 1'b0;
    end else begin
      if (complete && (!frame.frame_valid || accept)) begin
        frame.frame_digits <= slot_digits;
        frame.frame_blank  <= slot_blank;
        frame.frame_bad    <= slot_bad;
        frame.frame_valid  <= 1'b1;
      end else if (accept) begin
        frame.frame_valid <= 1'b0;
      end
      if (accept) begin
        frame.overrun <= 1'b0;
      end else if (complete && frame.frame_valid) begin
        frame.overrun <= 1'b1;
      end
    end
  end

endmodule
